sqrt_iter_gen: RTL and testbench

Parametrised, handshaked successor to the fixed-width iterative square-root unit. It takes one custom-float operand (sign, signed exponent, significand with explicit integer bit and special-value flags) and produces its square root with one restoring digit step per cycle. Mantissa/exponent width and the rounding mode are configurable. Input and output use valid/ready, and the result is held under back-pressure. It sits between the operand decoder and the result packer in the FP datapath.

---
 rtl/sqrt_gen_pkg.sv | 25 ++
 rtl/sqrt_digit_step.sv | 34 +++
 rtl/sqrt_iter_gen.sv | 161 ++++++++++++++++
 tb/tb_sqrt_iter_gen.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sqrt_gen_pkg.sv
// Shared types and encodings for the iterative square-root unit.
// The special-value encodings are built here so every user agrees on the same layout.
package sqrt_gen_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        FIN,
        DONE
    } state_t;

    typedef struct packed {
        logic [31:0] exp;
        logic [63:0] mant;
    } special_t;

    // Canonical NaN sets only the integer bit of the significand; inf leaves it clear.
    function automatic special_t special_code(input int mant_w, input int exp_special, input logic nan);
        special_t code;
        code.exp  = 32'(exp_special);
        code.mant = nan ? (64'(1) << (mant_w - 1)) : 64'(0);
        return code;
    endfunction

endpackage

// File: rtl/sqrt_digit_step.sv
// One restoring square-root digit: append two radicand bits to the remainder
// and retire one root bit, MSB first.
module sqrt_digit_step #(
    parameter int MANT_W   = 11,
    parameter int ROUND_EN = 1
) (
    input  logic [MANT_W+ROUND_EN+1:0] rem,
    input  logic [1:0]                 pair,
    input  logic [MANT_W+ROUND_EN-1:0] root,
    output logic [MANT_W+ROUND_EN+1:0] rem_next,
    output logic [MANT_W+ROUND_EN-1:0] root_next
);

    localparam int N     = MANT_W + ROUND_EN;
    localparam int REM_W = N + 2;

    logic [REM_W+1:0] rem_cat;
    logic [REM_W+1:0] trial;

    assign rem_cat = {rem, pair};
    assign trial   = {2'b00, root, 2'b01};

    always_comb begin
        rem_next  = rem;
        root_next = {root[N-2:0], 1'b0};
        if (rem_cat >= trial) begin
            rem_next  = REM_W'(rem_cat - trial);
            root_next = {root[N-2:0], 1'b1};
        end else begin
            rem_next  = REM_W'(rem_cat);
        end
    end

endmodule

// File: rtl/sqrt_iter_gen.sv
// Handshaked iterative square root of a custom float, one root bit per cycle.
// Specials resolve on accept; numbers run MANT_W+ROUND_EN restoring steps, then round.
module sqrt_iter_gen
    import sqrt_gen_pkg::*;
#(
    parameter int MANT_W      = 11,
    parameter int EXP_W       = 7,
    parameter int EXP_ZERO    = -15,
    parameter int EXP_SPECIAL = 16,
    parameter int ROUND_EN    = 1
) (
    input  logic                    clk,
    input  logic                    enable,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    sign_in,
    input  logic signed [EXP_W-1:0] exp_in,
    input  logic [MANT_W-1:0]       mant_in,
    input  logic                    is_nan_in,
    input  logic                    is_pinf_in,
    input  logic                    is_ninf_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    sign_out,
    output logic [EXP_W-1:0]        exp_out,
    output logic [MANT_W-1:0]       mant_out,
    output logic                    is_nan_out,
    output logic                    is_pinf_out,
    output logic                    is_ninf_out,
    output logic                    inexact_out
);

    localparam int N     = MANT_W + ROUND_EN;
    localparam int RAD_W = 2 * N;
    localparam int REM_W = N + 2;
    localparam int CNT_W = $clog2(N + 1);

    localparam special_t          NAN_CODE   = special_code(MANT_W, EXP_SPECIAL, 1'b1);
    localparam special_t          INF_CODE   = special_code(MANT_W, EXP_SPECIAL, 1'b0);
    localparam logic [EXP_W-1:0]  EXP_SPEC_V = NAN_CODE.exp[EXP_W-1:0];
    localparam logic [MANT_W-1:0] NAN_MANT   = NAN_CODE.mant[MANT_W-1:0];
    localparam logic [MANT_W-1:0] INF_MANT   = INF_CODE.mant[MANT_W-1:0];
    localparam logic [EXP_W-1:0]  EXP_ZERO_V = EXP_W'(EXP_ZERO);

    state_t state, state_next;

    logic [RAD_W-1:0]        rad;
    logic [RAD_W-1:0]        rad_ext;
    logic [REM_W-1:0]        rem, rem_next;
    logic [N-1:0]            root, root_next;
    logic [CNT_W-1:0]        cnt;
    logic [EXP_W-1:0]        exp_half;
    logic signed [EXP_W:0]   exp_adj;
    logic [MANT_W-1:0]       mant_round;
    logic                    accept, is_zero, special_path, guard;

    assign in_ready     = (state == IDLE) && enable;
    assign out_valid    = (state == DONE);
    assign accept       = in_valid && in_ready;
    assign is_zero      = (exp_in == EXP_ZERO_V) && (mant_in == '0);
    assign special_path = is_nan_in || is_pinf_in || is_ninf_in || is_zero || sign_in;
    assign exp_adj      = {exp_in[EXP_W-1], exp_in} - (EXP_W+1)'(exp_in[0]);
    assign rad_ext      = RAD_W'(mant_in);
    assign guard        = (ROUND_EN != 0) && root[0];
    assign mant_round   = root[N-1 -: MANT_W] + MANT_W'(guard);

    sqrt_digit_step #(
        .MANT_W   (MANT_W),
        .ROUND_EN (ROUND_EN)
    ) u_step (
        .rem       (rem),
        .pair      (rad[RAD_W-1 -: 2]),
        .root      (root),
        .rem_next  (rem_next),
        .root_next (root_next)
    );

    always_ff @(posedge clk) begin
        if (!enable) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = special_path ? DONE : ITER;
            ITER: if (cnt == CNT_W'(N - 1)) state_next = FIN;
            FIN:  state_next = DONE;
            DONE: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // An odd exponent is absorbed by doubling the significand so e' halves exactly.
    always_ff @(posedge clk) begin
        if (!enable) begin
            rad         <= '0;
            rem         <= '0;
            root        <= '0;
            cnt         <= '0;
            exp_half    <= '0;
            sign_out    <= 1'b0;
            exp_out     <= '0;
            mant_out    <= '0;
            is_nan_out  <= 1'b0;
            is_pinf_out <= 1'b0;
            is_ninf_out <= 1'b0;
            inexact_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        inexact_out <= 1'b0;
                        is_ninf_out <= 1'b0;
                        is_nan_out  <= 1'b0;
                        is_pinf_out <= 1'b0;
                        if (is_pinf_in && !is_nan_in) begin
                            sign_out    <= 1'b0;
                            exp_out     <= EXP_SPEC_V;
                            mant_out    <= INF_MANT;
                            is_pinf_out <= 1'b1;
                        end else if (is_zero && !is_nan_in && !is_ninf_in) begin
                            sign_out <= sign_in;
                            exp_out  <= EXP_ZERO_V;
                            mant_out <= '0;
                        end else if (special_path) begin
                            sign_out   <= 1'b1;
                            exp_out    <= EXP_SPEC_V;
                            mant_out   <= NAN_MANT;
                            is_nan_out <= 1'b1;
                        end else begin
                            rad      <= exp_in[0] ? rad_ext << (MANT_W + 2 * ROUND_EN)
                                                  : rad_ext << (MANT_W - 1 + 2 * ROUND_EN);
                            rem      <= '0;
                            root     <= '0;
                            cnt      <= '0;
                            exp_half <= EXP_W'(exp_adj >>> 1);
                        end
                    end
                end
                ITER: begin
                    rad  <= rad << 2;
                    rem  <= rem_next;
                    root <= root_next;
                    cnt  <= cnt + CNT_W'(1);
                end
                FIN: begin
                    sign_out    <= 1'b0;
                    exp_out     <= exp_half;
                    mant_out    <= mant_round;
                    is_nan_out  <= 1'b0;
                    is_pinf_out <= 1'b0;
                    is_ninf_out <= 1'b0;
                    inexact_out <= guard || (rem != '0);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sqrt_iter_gen.sv
// Self-checking bench for sqrt_iter_gen: directed test-plan vectors plus random
// operands checked against a value-level square-root model.
module tb_sqrt_iter_gen;

    localparam int MANT_W      = 11;
    localparam int EXP_W       = 7;
    localparam int EXP_ZERO    = -15;
    localparam int EXP_SPECIAL = 16;
    localparam int ROUND_EN    = 1;
    localparam int LAT_NUM     = MANT_W + ROUND_EN + 2;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-1:0] mant;
        logic              nan;
        logic              pinf;
        logic              ninf;
        logic              inexact;
    } res_t;

    logic                    clk = 1'b0;
    logic                    enable = 1'b0;
    logic                    in_valid = 1'b0;
    logic                    in_ready;
    logic                    sign_in = 1'b0;
    logic signed [EXP_W-1:0] exp_in = '0;
    logic [MANT_W-1:0]       mant_in = '0;
    logic                    is_nan_in = 1'b0;
    logic                    is_pinf_in = 1'b0;
    logic                    is_ninf_in = 1'b0;
    logic                    out_valid;
    logic                    out_ready = 1'b0;
    logic                    sign_out;
    logic [EXP_W-1:0]        exp_out;
    logic [MANT_W-1:0]       mant_out;
    logic                    is_nan_out, is_pinf_out, is_ninf_out, inexact_out;

    int n_cmp  = 0;
    int n_fail = 0;

    localparam res_t NAN_R  = {1'b1, 7'd16, 11'h400, 4'b1000};
    localparam res_t PINF_R = {1'b0, 7'd16, 11'h000, 4'b0100};

    always #5 clk = ~clk;

    sqrt_iter_gen #(
        .MANT_W      (MANT_W),
        .EXP_W       (EXP_W),
        .EXP_ZERO    (EXP_ZERO),
        .EXP_SPECIAL (EXP_SPECIAL),
        .ROUND_EN    (ROUND_EN)
    ) dut (
        .clk         (clk),
        .enable      (enable),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .sign_in     (sign_in),
        .exp_in      (exp_in),
        .mant_in     (mant_in),
        .is_nan_in   (is_nan_in),
        .is_pinf_in  (is_pinf_in),
        .is_ninf_in  (is_ninf_in),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .sign_out    (sign_out),
        .exp_out     (exp_out),
        .mant_out    (mant_out),
        .is_nan_out  (is_nan_out),
        .is_pinf_out (is_pinf_out),
        .is_ninf_out (is_ninf_out),
        .inexact_out (inexact_out)
    );

    function automatic res_t observed();
        return {sign_out, exp_out, mant_out, is_nan_out, is_pinf_out, is_ninf_out, inexact_out};
    endfunction

    function automatic longint isqrt(input longint v);
        longint r;
        r = longint'($sqrt(real'(v)));
        while (r * r > v) r--;
        while ((r + 1) * (r + 1) <= v) r++;
        return r;
    endfunction

    // Value-level reference: sqrt(m * 2^e) computed with integer square root.
    function automatic res_t model(input logic s, input int e, input int m,
                                   input logic nan, input logic pinf, input logic ninf);
        res_t   r;
        longint rad, root, rem, grd;
        int     e2;
        r = '0;
        if (nan || (!pinf && ninf)) return NAN_R;
        if (pinf) return PINF_R;
        if (e == EXP_ZERO && m == 0) begin
            r.sign = s;
            r.exp  = EXP_W'(EXP_ZERO);
            return r;
        end
        if (s) return NAN_R;
        if (e % 2 != 0) begin
            rad = 2 * longint'(m);
            e2  = e - 1;
        end else begin
            rad = longint'(m);
            e2  = e;
        end
        rad  = rad * (longint'(1) << (MANT_W - 1 + 2 * ROUND_EN));
        root = isqrt(rad);
        rem  = rad - root * root;
        grd  = (ROUND_EN != 0) ? root % 2 : 0;
        r.mant    = MANT_W'((ROUND_EN != 0) ? root / 2 + grd : root);
        r.exp     = EXP_W'(e2 / 2);
        r.inexact = (grd != 0) || (rem != 0);
        return r;
    endfunction

    task automatic drive_op(input logic s, input int e, input int m,
                            input logic nan, input logic pinf, input logic ninf);
        sign_in    = s;
        exp_in     = EXP_W'(e);
        mant_in    = MANT_W'(m);
        is_nan_in  = nan;
        is_pinf_in = pinf;
        is_ninf_in = ninf;
    endtask

    // Issues one operand, measures cycles until out_valid; optionally retires the result.
    task automatic run_op(input logic s, input int e, input int m,
                          input logic nan, input logic pinf, input logic ninf,
                          input bit pop, output res_t res, output int lat);
        int wait_c;
        wait_c = 0;
        res = '0;
        lat = -1;
        drive_op(s, e, m, nan, pinf, ninf);
        in_valid = 1'b1;
        while (!in_ready && wait_c < 50) begin
            @(posedge clk); #1;
            wait_c++;
        end
        if (!in_ready) begin
            n_cmp++; n_fail++;
            $display("[TB] FAIL accept_timeout: in_ready %b, required 1", in_ready);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_c = 1;
        while (!out_valid && wait_c < 40) begin
            @(posedge clk); #1;
            wait_c++;
        end
        if (!out_valid) begin
            n_cmp++; n_fail++;
            $display("[TB] FAIL result_timeout: out_valid %b, required 1", out_valid);
            return;
        end
        lat = wait_c;
        res = observed();
        if (pop) begin
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        enable = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (observed() !== res_t'(0)) begin
            n_fail++;
            $display("[TB] FAIL reset_outputs: got %h, required 0", observed());
        end
        n_cmp++;
        if ({out_valid, in_ready} !== 2'b00) begin
            n_fail++;
            $display("[TB] FAIL reset_handshake: got %b, required 00", {out_valid, in_ready});
        end
        enable = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL ready_after_reset: got %b, required 1", in_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_known();
        int   e_tab[4]   = '{2, 1, 3, 1};
        int   m_tab[4]   = '{'h400, 'h400, 'h480, 'h7FF};
        res_t exp_tab[4] = '{{1'b0, 7'd1, 11'h400, 4'b0000},
                             {1'b0, 7'd0, 11'h5A8, 4'b0001},
                             {1'b0, 7'd1, 11'h600, 4'b0000},
                             {1'b0, 7'd0, 11'h7FF, 4'b0001}};
        res_t res;
        int   lat;
        for (int i = 0; i < 4; i++) begin
            run_op(1'b0, e_tab[i], m_tab[i], 1'b0, 1'b0, 1'b0, 1'b1, res, lat);
            n_cmp++;
            if (res !== exp_tab[i]) begin
                n_fail++;
                $display("[TB] FAIL known_result[%0d]: got %h, required %h", i, res, exp_tab[i]);
            end
            n_cmp++;
            if (lat != LAT_NUM) begin
                n_fail++;
                $display("[TB] FAIL known_latency[%0d]: got %0d, required %0d", i, lat, LAT_NUM);
            end
        end
    endtask

    task automatic test_specials();
        logic s_tab[5]   = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        int   e_tab[5]   = '{-15, 1, 0, 0, 0};
        int   m_tab[5]   = '{0, 'h600, 'h400, 'h400, 'h400};
        logic [2:0] f_tab[5] = '{3'b000, 3'b000, 3'b001, 3'b010, 3'b100};
        res_t exp_tab[5] = '{{1'b1, 7'h71, 11'h000, 4'b0000}, NAN_R, NAN_R, PINF_R, NAN_R};
        res_t res;
        int   lat;
        for (int i = 0; i < 5; i++) begin
            run_op(s_tab[i], e_tab[i], m_tab[i], f_tab[i][2], f_tab[i][1], f_tab[i][0],
                   1'b1, res, lat);
            n_cmp++;
            if (res !== exp_tab[i]) begin
                n_fail++;
                $display("[TB] FAIL special_result[%0d]: got %h, required %h", i, res, exp_tab[i]);
            end
            n_cmp++;
            if (lat != 1) begin
                n_fail++;
                $display("[TB] FAIL special_latency[%0d]: got %0d, required 1", i, lat);
            end
        end
    endtask

    task automatic test_random();
        res_t res, want;
        int   lat, cls, e, m;
        logic s, nan, pinf, ninf;
        for (int i = 0; i < 40; i++) begin
            cls  = int'($urandom_range(0, 9));
            s    = 1'b0; nan = 1'b0; pinf = 1'b0; ninf = 1'b0;
            e    = int'($urandom_range(0, 29)) - 14;
            m    = 1024 + int'($urandom_range(0, 1023));
            case (cls)
                0: begin nan = 1'b1; pinf = 1'($urandom); ninf = 1'($urandom); end
                1: begin pinf = 1'b1; ninf = 1'($urandom); end
                2: ninf = 1'b1;
                3: begin e = EXP_ZERO; m = 0; s = 1'($urandom); end
                4: s = 1'b1;
                default: ;
            endcase
            want = model(s, e, m, nan, pinf, ninf);
            run_op(s, e, m, nan, pinf, ninf, 1'b1, res, lat);
            n_cmp++;
            if (res !== want) begin
                n_fail++;
                $display("[TB] FAIL random_result[%0d] e=%0d m=%h: got %h, required %h",
                         i, e, m, res, want);
            end
            n_cmp++;
            if (lat != ((cls <= 4) ? 1 : LAT_NUM)) begin
                n_fail++;
                $display("[TB] FAIL random_latency[%0d]: got %0d, required %0d",
                         i, lat, (cls <= 4) ? 1 : LAT_NUM);
            end
        end
    endtask

    task automatic test_backpressure();
        res_t held, want;
        int   lat;
        want = {1'b0, 7'd1, 11'h400, 4'b0000};
        run_op(1'b0, 2, 'h400, 1'b0, 1'b0, 1'b0, 1'b0, held, lat);
        n_cmp++;
        if (held !== want) begin
            n_fail++;
            $display("[TB] FAIL bp_result: got %h, required %h", held, want);
        end
        for (int i = 0; i < 5; i++) begin
            drive_op(1'b0, 3, 'h480, 1'b0, 1'b0, 1'b0);
            in_valid = 1'b1;
            @(posedge clk); #1;
            n_cmp++;
            if ({out_valid, in_ready} !== 2'b10) begin
                n_fail++;
                $display("[TB] FAIL bp_handshake[%0d]: got %b, required 10", i, {out_valid, in_ready});
            end
            n_cmp++;
            if (observed() !== want) begin
                n_fail++;
                $display("[TB] FAIL bp_stable[%0d]: got %h, required %h", i, observed(), want);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_cmp++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_fail++;
            $display("[TB] FAIL bp_release: got %b, required 01", {out_valid, in_ready});
        end
    endtask

    task automatic test_back_to_back();
        res_t got[2];
        int   acc_c[2];
        int   nacc, nres;
        bit   acc;
        res_t want0, want1;
        want0 = {1'b0, 7'd1, 11'h400, 4'b0000};
        want1 = {1'b0, 7'd1, 11'h600, 4'b0000};
        got[0] = '0; got[1] = '0; acc_c[0] = 0; acc_c[1] = 0;
        nacc = 0; nres = 0;
        drive_op(1'b0, 2, 'h400, 1'b0, 1'b0, 1'b0);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 80 && nres < 2; c++) begin
            acc = in_valid && in_ready;
            if (out_valid) begin
                got[nres] = observed();
                nres++;
            end
            @(posedge clk); #1;
            if (acc) begin
                acc_c[nacc] = c;
                nacc++;
                if (nacc == 1) drive_op(1'b0, 3, 'h480, 1'b0, 1'b0, 1'b0);
                else           in_valid = 1'b0;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        n_cmp++;
        if (nacc != 2 || acc_c[1] - acc_c[0] != LAT_NUM + 1) begin
            n_fail++;
            $display("[TB] FAIL b2b_interval: got %0d accepts %0d apart, required 2 accepts %0d apart",
                     nacc, acc_c[1] - acc_c[0], LAT_NUM + 1);
        end
        n_cmp++;
        if (got[0] !== want0 || got[1] !== want1) begin
            n_fail++;
            $display("[TB] FAIL b2b_results: got %h %h, required %h %h", got[0], got[1], want0, want1);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_iter();
        res_t res, want;
        int   lat, seen;
        want = {1'b0, 7'd1, 11'h400, 4'b0000};
        drive_op(1'b0, 2, 'h400, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL rst_pre_ready: got %b, required 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        enable = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if ({observed(), out_valid, in_ready} !== '0) begin
            n_fail++;
            $display("[TB] FAIL rst_mid_outputs: got %h/%b/%b, required all 0",
                     observed(), out_valid, in_ready);
        end
        enable = 1'b1;
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        n_cmp++;
        if (seen != 0) begin
            n_fail++;
            $display("[TB] FAIL rst_no_result: got %0d valid cycles, required 0", seen);
        end
        run_op(1'b0, 2, 'h400, 1'b0, 1'b0, 1'b0, 1'b1, res, lat);
        n_cmp++;
        if (res !== want || lat != LAT_NUM) begin
            n_fail++;
            $display("[TB] FAIL rst_recover: got %h lat %0d, required %h lat %0d",
                     res, lat, want, LAT_NUM);
        end
    endtask

    initial begin
        $display("[TB] sqrt_iter_gen bench start");
        test_reset();
        test_known();
        test_specials();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_iter();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
